// File: rtl/grant_tenure_if.sv
// Handshake bundle between the arbiter/requester side (master) and
// grant_tenure_ctrl (slave).
interface grant_tenure_if #(
  parameter int NUM_REQUESTS = 4,
  parameter int MAX_BEATS    = 16
);
  localparam int IDW = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;
  localparam int LW  = $clog2(MAX_BEATS + 1);

  logic [NUM_REQUESTS-1:0] grant;
  logic [NUM_REQUESTS-1:0] req;
  logic [LW-1:0]           len_in;
  logic                    beat_ready;
  logic                    busy;
  logic                    owner_valid;
  logic [IDW-1:0]          owner_id;
  logic                    beat_valid;
  logic [LW-1:0]           beat_cnt;
  logic [NUM_REQUESTS-1:0] release_onehot;
  logic                    onehot_err;
  logic                    timeout_err;

  modport master (
    output grant, req, len_in, beat_ready,
    input  busy, owner_valid, owner_id, beat_valid, beat_cnt,
           release_onehot, onehot_err, timeout_err
  );

  modport slave (
    input  grant, req, len_in, beat_ready,
    output busy, owner_valid, owner_id, beat_valid, beat_cnt,
           release_onehot, onehot_err, timeout_err
  );
endinterface

// File: rtl/grant_tenure_ctrl.sv
// Latches a one-hot grant, runs the owner's burst against a ready handshake,
// then pulses a one-hot release. Rejects multi-hot grants, stalls, withdrawal.
module grant_tenure_ctrl #(
  parameter int NUM_REQUESTS = 4,
  parameter int MAX_BEATS    = 16,
  parameter int TIMEOUT      = 32
) (
  input logic           clk,
  input logic           reset,
  grant_tenure_if.slave bus
);
  localparam int IDW   = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;
  localparam int LW    = $clog2(MAX_BEATS + 1);
  localparam int SW    = $clog2(TIMEOUT + 1);
  localparam int CNT_W = $clog2(NUM_REQUESTS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RELEASE
  } state_t;

  state_t                  state_reg;
  logic [IDW-1:0]          owner_id_reg;
  logic [LW-1:0]           len_reg;
  logic [LW-1:0]           beat_cnt_reg;
  logic [SW-1:0]           stall_reg;
  logic                    busy_reg;
  logic                    owner_valid_reg;
  logic                    beat_valid_reg;
  logic [NUM_REQUESTS-1:0] release_reg;
  logic                    onehot_err_reg;
  logic                    timeout_err_reg;

  logic [CNT_W-1:0]        grant_count;
  logic [IDW-1:0]          grant_idx;
  logic [LW-1:0]           len_clamped;
  logic [NUM_REQUESTS-1:0] owner_onehot;
  logic [LW-1:0]           beat_cnt_inc;
  logic [SW-1:0]           stall_inc;
  logic                    withdraw;
  logic                    accept;
  logic                    stall_expired;
  logic                    finish;

  always_comb begin
    grant_count = '0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQUESTS; i++) begin
      if (bus.grant[i]) begin
        grant_count = grant_count + 1'b1;
        grant_idx   = IDW'(i);
      end
    end
  end

  // A zero length still moves one beat; oversize bursts are clipped.
  always_comb begin
    if (bus.len_in == '0) begin
      len_clamped = LW'(1);
    end else if (bus.len_in > LW'(MAX_BEATS)) begin
      len_clamped = LW'(MAX_BEATS);
    end else begin
      len_clamped = bus.len_in;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQUESTS; gi++) begin : g_owner_dec
      assign owner_onehot[gi] = (owner_id_reg == IDW'(gi));
    end
  endgenerate

  // Withdrawal outranks completion; completion and timeout are exclusive.
  assign beat_cnt_inc  = beat_cnt_reg + 1'b1;
  assign stall_inc     = stall_reg + 1'b1;
  assign withdraw      = ~bus.req[owner_id_reg];
  assign accept        = beat_valid_reg & bus.beat_ready;
  assign stall_expired = ~accept & (stall_inc == SW'(TIMEOUT));
  assign finish        = withdraw | (accept & (beat_cnt_inc == len_reg)) | stall_expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      owner_id_reg    <= '0;
      len_reg         <= '0;
      beat_cnt_reg    <= '0;
      stall_reg       <= '0;
      busy_reg        <= 1'b0;
      owner_valid_reg <= 1'b0;
      beat_valid_reg  <= 1'b0;
      release_reg     <= '0;
      onehot_err_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      release_reg     <= '0;
      onehot_err_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_count == CNT_W'(1)) begin
            state_reg       <= ST_ACTIVE;
            owner_id_reg    <= grant_idx;
            len_reg         <= len_clamped;
            beat_cnt_reg    <= '0;
            stall_reg       <= '0;
            busy_reg        <= 1'b1;
            owner_valid_reg <= 1'b1;
            beat_valid_reg  <= 1'b1;
          end else if (grant_count > CNT_W'(1)) begin
            onehot_err_reg <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!withdraw) begin
            if (accept) begin
              beat_cnt_reg <= beat_cnt_inc;
              stall_reg    <= '0;
            end else begin
              stall_reg <= stall_inc;
            end
            timeout_err_reg <= stall_expired;
          end
          if (finish) begin
            state_reg      <= ST_RELEASE;
            beat_valid_reg <= 1'b0;
            release_reg    <= owner_onehot;
          end
        end
        ST_RELEASE: begin
          state_reg       <= ST_IDLE;
          busy_reg        <= 1'b0;
          owner_valid_reg <= 1'b0;
          owner_id_reg    <= '0;
          beat_cnt_reg    <= '0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy           = busy_reg;
  assign bus.owner_valid    = owner_valid_reg;
  assign bus.owner_id       = owner_id_reg;
  assign bus.beat_valid     = beat_valid_reg;
  assign bus.beat_cnt       = beat_cnt_reg;
  assign bus.release_onehot = release_reg;
  assign bus.onehot_err     = onehot_err_reg;
  assign bus.timeout_err    = timeout_err_reg;
endmodule

// File: tb/tb_grant_tenure_ctrl.sv
// Bench for grant_tenure_ctrl: directed corner cases plus randomized tenures
// checked against a per-tenure outcome model built from the ready/withdraw plan.
module tb_grant_tenure_ctrl;
  localparam int NR = 4;
  localparam int MB = 16;
  localparam int TO = 32;
  localparam int PLAN = 600;

  logic clk = 1'b0;
  logic reset;

  grant_tenure_if #(.NUM_REQUESTS(NR), .MAX_BEATS(MB)) bus ();

  grant_tenure_ctrl #(.NUM_REQUESTS(NR), .MAX_BEATS(MB), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int tenures  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"}, bus.busy, 0);
    check_eq({tag, "_ovalid"}, bus.owner_valid, 0);
    check_eq({tag, "_oid"}, bus.owner_id, 0);
    check_eq({tag, "_bvalid"}, bus.beat_valid, 0);
    check_eq({tag, "_cnt"}, bus.beat_cnt, 0);
    check_eq({tag, "_rel"}, bus.release_onehot, 0);
    check_eq({tag, "_tmo"}, bus.timeout_err, 0);
  endtask

  // Called while the DUT sits in IDLE; returns with the DUT back in IDLE.
  task automatic run_tenure(input logic [3:0] gnt, input logic [4:0] len,
                            input int ready_mode, input int withdraw_at);
    bit  rdy [PLAN];
    int  cnt_after [PLAN];
    int  eff_len, owner, beats, stall, end_k, reason;
    logic [3:0] r;
    string why;

    eff_len = (len == 0) ? 1 : ((len > MB) ? MB : int'(len));
    owner = 0;
    for (int i = 0; i < NR; i++) if (gnt[i]) owner = i;
    for (int k = 0; k < PLAN; k++) begin
      if (ready_mode == 0)      rdy[k] = 1'b1;
      else if (ready_mode == 1) rdy[k] = 1'b0;
      else                      rdy[k] = ($urandom_range(0, 99) < 70);
    end

    beats = 0; stall = 0; end_k = -1; reason = 0;
    for (int k = 0; k < PLAN && end_k < 0; k++) begin
      if (k == withdraw_at) begin
        reason = 1; end_k = k;
      end else if (rdy[k]) begin
        beats++; stall = 0;
        if (beats == eff_len) begin reason = 0; end_k = k; end
      end else begin
        stall++;
        if (stall == TO) begin reason = 2; end_k = k; end
      end
      cnt_after[k] = beats;
    end

    bus.grant = gnt;
    bus.len_in = len;
    bus.req = 4'($urandom_range(0, 15)) | gnt;
    bus.beat_ready = 1'($urandom_range(0, 1));
    tick();
    check_eq("acc_busy", bus.busy, 1);
    check_eq("acc_ovalid", bus.owner_valid, 1);
    check_eq("acc_oid", bus.owner_id, owner);
    check_eq("acc_bvalid", bus.beat_valid, 1);
    check_eq("acc_cnt", bus.beat_cnt, 0);

    for (int k = 0; k <= end_k; k++) begin
      bus.grant = 4'($urandom_range(0, 15));
      bus.len_in = 5'($urandom_range(0, 31));
      bus.beat_ready = rdy[k];
      r = 4'($urandom_range(0, 15));
      r[owner] = (k != withdraw_at);
      bus.req = r;
      tick();
      check_eq("act_cnt", bus.beat_cnt, cnt_after[k]);
      check_eq("act_busy", bus.busy, 1);
      check_eq("act_oerr", bus.onehot_err, 0);
      if (k < end_k) begin
        check_eq("act_bvalid", bus.beat_valid, 1);
        check_eq("act_rel", bus.release_onehot, 0);
        check_eq("act_tmo", bus.timeout_err, 0);
      end else begin
        check_eq("rel_onehot", bus.release_onehot, gnt);
        check_eq("rel_bvalid", bus.beat_valid, 0);
        check_eq("rel_ovalid", bus.owner_valid, 1);
        check_eq("rel_oid", bus.owner_id, owner);
        check_eq("rel_tmo", bus.timeout_err, (reason == 2));
      end
    end

    bus.grant = 4'($urandom_range(0, 15));
    bus.beat_ready = 1'($urandom_range(0, 1));
    bus.req = 4'($urandom_range(0, 15));
    tick();
    check_quiet("post");
    check_eq("post_oerr", bus.onehot_err, 0);
    bus.grant = '0;
    bus.req = '0;

    why = (reason == 0) ? "done" : ((reason == 1) ? "withdraw" : "timeout");
    $display("tenure %0d: grant=%b len_in=%0d eff_len=%0d beats=%0d end=%s active_cycles=%0d",
             tenures, gnt, len, eff_len, beats, why, end_k + 1);
    tenures++;
  endtask

  task automatic multi_grant(input logic [3:0] gnt);
    bus.grant = gnt;
    bus.len_in = 5'($urandom_range(0, 31));
    tick();
    check_eq("oh_err", bus.onehot_err, 1);
    check_eq("oh_busy", bus.busy, 0);
    check_eq("oh_ovalid", bus.owner_valid, 0);
    bus.grant = '0;
    tick();
    check_eq("oh_clear", bus.onehot_err, 0);
    check_eq("oh_busy2", bus.busy, 0);
    $display("multi-grant: grant=%b rejected", gnt);
  endtask

  task automatic reset_mid_tenure();
    bus.grant = 4'b0001;
    bus.len_in = 5'd5;
    bus.req = 4'b0001;
    bus.beat_ready = 1'b1;
    tick();
    bus.grant = '0;
    tick();
    tick();
    check_eq("mid_cnt", bus.beat_cnt, 2);
    #2 reset = 1'b1;
    #1;
    check_quiet("rst_async");
    check_eq("rst_async_oerr", bus.onehot_err, 0);
    tick();
    check_quiet("rst_held");
    reset = 1'b0;
    bus.req = '0;
    tick();
    check_quiet("rst_after");
    $display("reset mid-tenure: outputs cleared, no release");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, wd;
    logic [3:0] g;
    reset = 1'b1;
    bus.grant = '0;
    bus.req = '0;
    bus.len_in = '0;
    bus.beat_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b0;
    tick();
    check_quiet("idle0");

    reset_mid_tenure();
    run_tenure(4'b0100, 5'd3, 0, -1);
    multi_grant(4'b0011);
    run_tenure(4'b0001, 5'd2, 0, -1);
    run_tenure(4'b1000, 5'd4, 1, -1);
    run_tenure(4'b0010, 5'd8, 0, 2);
    run_tenure(4'b0001, 5'd0, 0, -1);
    run_tenure(4'b0100, 5'd20, 0, -1);
    run_tenure(4'b0010, 5'd16, 0, 0);

    for (int n = 0; n < 40; n++) begin
      g = 4'b0001 << $urandom_range(0, 3);
      mode = $urandom_range(0, 9);
      mode = (mode == 0) ? 1 : ((mode <= 3) ? 0 : 2);
      wd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_tenure(g, 5'($urandom_range(0, 31)), mode, wd);
      if ($urandom_range(0, 4) == 0) multi_grant(4'b0101 << $urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          tick();
          check_eq("gap_busy", bus.busy, 0);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
